// File: rtl/wb_arbiter_if.sv
// Writeback bus between the ALU/load producers and the register-file arbiter.
// The slave modport is the arbiter's view; master is the producer/consumer side.
interface wb_arbiter_if;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned CNT_W  = 2;

  logic             alu_valid;
  logic             alu_ready;
  logic [REG_W-1:0] alu_rd;
  logic [XLEN-1:0]  alu_val;

  logic             ld_valid;
  logic             ld_ready;
  logic [REG_W-1:0] ld_rd;
  logic [XLEN-1:0]  ld_data;
  logic [2:0]       ld_funct3;
  logic [1:0]       ld_addr_lo;

  logic             w_enable;
  logic [REG_W-1:0] w_reg_name;
  logic [XLEN-1:0]  w_reg_val;
  logic [CNT_W-1:0] alu_fifo_count;

  modport slave (
    input  alu_valid, alu_rd, alu_val,
    input  ld_valid, ld_rd, ld_data, ld_funct3, ld_addr_lo,
    output alu_ready, ld_ready,
    output w_enable, w_reg_name, w_reg_val, alu_fifo_count
  );

  modport master (
    output alu_valid, alu_rd, alu_val,
    output ld_valid, ld_rd, ld_data, ld_funct3, ld_addr_lo,
    input  alu_ready, ld_ready,
    input  w_enable, w_reg_name, w_reg_val, alu_fifo_count
  );
endinterface

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: loads win, ALU results queue in a 2-entry
// FIFO, and a starvation counter forces the FIFO head through periodically.
module wb_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  wb_arbiter_if.slave  bus
);
  localparam int unsigned REG_W   = 5;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned DEPTH   = 2;
  localparam int unsigned STARV_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  val;
  } fifo_entry_t;

  typedef enum logic [1:0] {
    WIN_NONE,
    WIN_LD,
    WIN_FIFO,
    WIN_ALU
  } win_t;

  fifo_entry_t        fifo_q [DEPTH];
  fifo_entry_t        fifo_d [DEPTH];
  logic [1:0]         count_q, count_d;
  logic [STARV_W-1:0] starve_q, starve_d;
  logic               w_en_q;
  logic [REG_W-1:0]   w_name_q;
  logic [XLEN-1:0]    w_val_q;

  logic               fifo_ne;
  logic               starved;
  logic               alu_acc;
  logic               ld_acc;
  win_t               win;
  logic [REG_W-1:0]   win_rd;
  logic [XLEN-1:0]    win_val;
  logic               deq;
  logic               enq;
  logic               do_write;

  // RV32I load extension; halfword select ignores addr_lo[0], lw ignores addr_lo.
  function automatic logic [XLEN-1:0] extend_load(input logic [2:0] funct3,
                                                   input logic [1:0] lo,
                                                   input logic [XLEN-1:0] data);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = data[7:0];
      2'd1:    b = data[15:8];
      2'd2:    b = data[23:16];
      default: b = data[31:24];
    endcase
    h = lo[1] ? data[31:16] : data[15:0];
    case (funct3)
      3'b000:  extend_load = {{24{b[7]}}, b};
      3'b001:  extend_load = {{16{h[15]}}, h};
      3'b010:  extend_load = data;
      3'b100:  extend_load = {24'd0, b};
      3'b101:  extend_load = {16'd0, h};
      default: extend_load = '0;
    endcase
  endfunction

  assign fifo_ne = (count_q != 2'd0);
  assign starved = fifo_ne && (starve_q == STARV_W'(STARVE_MAX));

  assign bus.alu_ready      = rst_n && (count_q != 2'(DEPTH));
  assign bus.ld_ready       = rst_n && !starved;
  assign bus.w_enable       = w_en_q;
  assign bus.w_reg_name     = w_name_q;
  assign bus.w_reg_val      = w_val_q;
  assign bus.alu_fifo_count = count_q;

  assign alu_acc = bus.alu_valid && bus.alu_ready;
  assign ld_acc  = bus.ld_valid && bus.ld_ready;

  // Winner priority: load, then FIFO head, then same-cycle ALU bypass.
  always_comb begin
    win     = WIN_NONE;
    win_rd  = '0;
    win_val = '0;
    if (ld_acc) begin
      win     = WIN_LD;
      win_rd  = bus.ld_rd;
      win_val = extend_load(bus.ld_funct3, bus.ld_addr_lo, bus.ld_data);
    end else if (fifo_ne) begin
      win     = WIN_FIFO;
      win_rd  = fifo_q[0].rd;
      win_val = fifo_q[0].val;
    end else if (alu_acc) begin
      win     = WIN_ALU;
      win_rd  = bus.alu_rd;
      win_val = bus.alu_val;
    end
  end

  assign deq      = (win == WIN_FIFO);
  assign enq      = alu_acc && (win != WIN_ALU);
  assign do_write = (win != WIN_NONE) && (win_rd != '0);

  // Shift-style FIFO: pop first, then append at the post-pop tail.
  always_comb begin
    fifo_d  = fifo_q;
    count_d = count_q;
    if (deq) begin
      fifo_d[0] = fifo_q[1];
      count_d   = count_q - 2'd1;
    end
    if (enq) begin
      fifo_d[count_d[0]] = '{rd: bus.alu_rd, val: bus.alu_val};
      count_d            = count_d + 2'd1;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!fifo_ne) begin
      starve_d = '0;
    end else if (win == WIN_LD) begin
      starve_d = starve_q + STARV_W'(1);
    end else if (win != WIN_NONE) begin
      starve_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q  <= '0;
      starve_q <= '0;
      w_en_q   <= 1'b0;
      w_name_q <= '0;
      w_val_q  <= '0;
    end else begin
      count_q  <= count_d;
      starve_q <= starve_d;
      w_en_q   <= do_write;
      if (do_write) begin
        w_name_q <= win_rd;
        w_val_q  <= win_val;
      end
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: table-driven load extension plus
// hand-written bypass, collision, ordering, starvation and reset sequences.
module tb_wb_arbiter;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  wb_arbiter_if bus ();

  wb_arbiter #(.STARVE_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] val;
  } wr_t;

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [31:0] data;
    logic [4:0]  rd;
    logic [31:0] val;
    logic        en;
  } ext_vec_t;

  wr_t      sb [$];
  ext_vec_t vecs [$];
  int       checks = 0;
  int       errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] val);
    sb.push_back('{rd: rd, val: val});
  endtask

  // Advance one cycle and score any register-file write against the queue.
  task automatic step();
    wr_t e;
    @(posedge clk);
    #1;
    if (bus.w_enable === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got x%0d=0x%08h, expected no write",
                 bus.w_reg_name, bus.w_reg_val);
      end else begin
        e = sb.pop_front();
        chk("w_reg_name", 32'(bus.w_reg_name), 32'(e.rd));
        chk("w_reg_val", bus.w_reg_val, e.val);
      end
    end
  endtask

  task automatic idle();
    bus.alu_valid  = 1'b0;
    bus.alu_rd     = '0;
    bus.alu_val    = '0;
    bus.ld_valid   = 1'b0;
    bus.ld_rd      = '0;
    bus.ld_data    = '0;
    bus.ld_funct3  = '0;
    bus.ld_addr_lo = '0;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [31:0] val);
    bus.alu_valid = 1'b1;
    bus.alu_rd    = rd;
    bus.alu_val   = val;
  endtask

  task automatic drive_ld(input logic [4:0] rd, input logic [2:0] f3,
                          input logic [1:0] lo, input logic [31:0] data);
    bus.ld_valid   = 1'b1;
    bus.ld_rd      = rd;
    bus.ld_funct3  = f3;
    bus.ld_addr_lo = lo;
    bus.ld_data    = data;
  endtask

  task automatic add_vec(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] data,
                         input logic [4:0] rd, input logic [31:0] val, input logic en);
    vecs.push_back('{f3: f3, lo: lo, data: data, rd: rd, val: val, en: en});
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && sb.size() != 0; i++) step();
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected $finish earlier");
    $fatal(1, "watchdog expired");
  end

  initial begin
    add_vec(3'b000, 2'd3, 32'h80FF7F01, 5'd1,  32'hFFFFFF80, 1'b1);
    add_vec(3'b100, 2'd1, 32'h80FF7F01, 5'd2,  32'h0000007F, 1'b1);
    add_vec(3'b001, 2'd2, 32'h80FF7F01, 5'd3,  32'hFFFF80FF, 1'b1);
    add_vec(3'b101, 2'd0, 32'h80FF7F01, 5'd4,  32'h00007F01, 1'b1);
    add_vec(3'b000, 2'd0, 32'h80FF7F01, 5'd5,  32'h00000001, 1'b1);
    add_vec(3'b000, 2'd2, 32'h80FF7F01, 5'd6,  32'hFFFFFFFF, 1'b1);
    add_vec(3'b001, 2'd3, 32'h80FF7F01, 5'd7,  32'hFFFF80FF, 1'b1);
    add_vec(3'b101, 2'd1, 32'h80FF7F01, 5'd8,  32'h00007F01, 1'b1);
    add_vec(3'b010, 2'd2, 32'h80FF7F01, 5'd9,  32'h80FF7F01, 1'b1);
    add_vec(3'b100, 2'd3, 32'h80FF7F01, 5'd10, 32'h00000080, 1'b1);
    add_vec(3'b001, 2'd1, 32'h12348765, 5'd11, 32'h00001234 ^ 32'h0 ^ 32'hFFFF8765 ^ 32'h00001234, 1'b1);
    add_vec(3'b011, 2'd0, 32'h80FF7F01, 5'd12, 32'h00000000, 1'b1);
    add_vec(3'b110, 2'd1, 32'h80FF7F01, 5'd13, 32'h00000000, 1'b1);
    add_vec(3'b111, 2'd2, 32'h80FF7F01, 5'd14, 32'h00000000, 1'b1);
    add_vec(3'b010, 2'd0, 32'hCAFEF00D, 5'd0,  32'h00000000, 1'b0);

    // Reset state
    idle();
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_w_enable",   32'(bus.w_enable),       32'd0);
    chk("rst_w_reg_name", 32'(bus.w_reg_name),     32'd0);
    chk("rst_w_reg_val",  bus.w_reg_val,           32'd0);
    chk("rst_count",      32'(bus.alu_fifo_count), 32'd0);
    chk("rst_alu_ready",  32'(bus.alu_ready),      32'd0);
    chk("rst_ld_ready",   32'(bus.ld_ready),       32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_alu_ready", 32'(bus.alu_ready), 32'd1);
    chk("post_rst_ld_ready",  32'(bus.ld_ready),  32'd1);

    // ALU bypass with empty FIFO
    drive_alu(5'd5, 32'h1234);
    push(5'd5, 32'h1234);
    step();
    chk("bypass_en",    32'(bus.w_enable),       32'd1);
    chk("bypass_count", 32'(bus.alu_fifo_count), 32'd0);
    idle();
    step();
    chk("idle_en",        32'(bus.w_enable),   32'd0);
    chk("idle_hold_name", 32'(bus.w_reg_name), 32'd5);
    chk("idle_hold_val",  bus.w_reg_val,       32'h1234);

    // Load extension table, one load per cycle
    foreach (vecs[i]) begin
      drive_ld(vecs[i].rd, vecs[i].f3, vecs[i].lo, vecs[i].data);
      if (vecs[i].en) push(vecs[i].rd, vecs[i].val);
      step();
      chk($sformatf("ext%0d_en", i), 32'(bus.w_enable), 32'(vecs[i].en));
    end
    idle();
    step();

    // rd=0 ALU winner is consumed without a write
    drive_alu(5'd0, 32'h55);
    step();
    chk("alu_rd0_en",    32'(bus.w_enable),       32'd0);
    chk("alu_rd0_count", 32'(bus.alu_fifo_count), 32'd0);
    idle();

    // Load/ALU collision
    drive_ld(5'd3, 3'b010, 2'd1, 32'hDEADBEEF);
    drive_alu(5'd4, 32'd7);
    push(5'd3, 32'hDEADBEEF);
    push(5'd4, 32'd7);
    step();
    chk("col_en1",    32'(bus.w_enable),       32'd1);
    chk("col_count1", 32'(bus.alu_fifo_count), 32'd1);
    idle();
    step();
    chk("col_en2",    32'(bus.w_enable),       32'd1);
    chk("col_count2", 32'(bus.alu_fifo_count), 32'd0);
    step();
    chk("col_idle_en", 32'(bus.w_enable), 32'd0);

    // ALU ordering through the FIFO with simultaneous pop and push
    drive_ld(5'd6, 3'b010, 2'd0, 32'h66666666);
    drive_alu(5'd7, 32'hA0A0_0007);
    push(5'd6, 32'h66666666);
    push(5'd7, 32'hA0A0_0007);
    step();
    idle();
    drive_alu(5'd8, 32'hA0A0_0008);
    push(5'd8, 32'hA0A0_0008);
    step();
    chk("ord_count_a", 32'(bus.alu_fifo_count), 32'd1);
    drive_alu(5'd9, 32'hA0A0_0009);
    push(5'd9, 32'hA0A0_0009);
    step();
    chk("ord_count_b", 32'(bus.alu_fifo_count), 32'd1);
    idle();
    step();
    chk("ord_count_c", 32'(bus.alu_fifo_count), 32'd0);
    drain(4);

    // Starvation: loads keep winning until the counter hits STARVE_MAX
    drive_ld(5'd10, 3'b010, 2'd0, 32'h1000_0010);
    drive_alu(5'd20, 32'hAAAA_0020);
    push(5'd10, 32'h1000_0010);
    step();
    chk("st_count1", 32'(bus.alu_fifo_count), 32'd1);
    drive_ld(5'd11, 3'b010, 2'd0, 32'h1000_0011);
    drive_alu(5'd21, 32'hBBBB_0021);
    push(5'd11, 32'h1000_0011);
    step();
    chk("st_count2",     32'(bus.alu_fifo_count), 32'd2);
    chk("full_alu_ready", 32'(bus.alu_ready),     32'd0);
    bus.alu_valid = 1'b0;
    for (int k = 12; k <= 14; k++) begin
      chk($sformatf("st_ld_ready_pre%0d", k), 32'(bus.ld_ready), 32'd1);
      drive_ld(5'(k), 3'b010, 2'd0, 32'h1000_0000 + 32'(k));
      push(5'(k), 32'h1000_0000 + 32'(k));
      step();
    end
    chk("st_ld_ready_blocked", 32'(bus.ld_ready),       32'd0);
    chk("st_count_full",       32'(bus.alu_fifo_count), 32'd2);
    drive_ld(5'd15, 3'b010, 2'd0, 32'h1000_0015);
    push(5'd20, 32'hAAAA_0020);
    step();
    chk("st_head_en",     32'(bus.w_enable),       32'd1);
    chk("st_count_after", 32'(bus.alu_fifo_count), 32'd1);
    chk("st_ld_ready_rel", 32'(bus.ld_ready),      32'd1);
    push(5'd15, 32'h1000_0015);
    step();
    idle();
    push(5'd21, 32'hBBBB_0021);
    step();
    chk("st_count_end", 32'(bus.alu_fifo_count), 32'd0);
    drain(4);

    // Reset with a full FIFO discards both entries
    drive_ld(5'd16, 3'b010, 2'd0, 32'h1600_0016);
    drive_alu(5'd22, 32'hCCCC_0022);
    push(5'd16, 32'h1600_0016);
    step();
    drive_ld(5'd17, 3'b010, 2'd0, 32'h1700_0017);
    drive_alu(5'd23, 32'hEEEE_0023);
    push(5'd17, 32'h1700_0017);
    step();
    chk("rr_count_full", 32'(bus.alu_fifo_count), 32'd2);
    rst_n = 1'b0;
    idle();
    drive_alu(5'd24, 32'h99);
    #1;
    chk("rr_alu_ready", 32'(bus.alu_ready), 32'd0);
    chk("rr_ld_ready",  32'(bus.ld_ready),  32'd0);
    step();
    chk("rr_count",  32'(bus.alu_fifo_count), 32'd0);
    chk("rr_w_en",   32'(bus.w_enable),       32'd0);
    chk("rr_w_name", 32'(bus.w_reg_name),     32'd0);
    chk("rr_w_val",  bus.w_reg_val,           32'd0);
    step();
    idle();
    rst_n = 1'b1;
    repeat (4) step();
    chk("rr_post_count", 32'(bus.alu_fifo_count), 32'd0);
    chk("rr_post_en",    32'(bus.w_enable),       32'd0);
    drain(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
